cv_key_matrix: RTL and testbench

CV_KEY_MATRIX -- requirements
Module: cv_key_matrix

---
 rtl/cv_key_matrix.sv | 211 +++++++++++++++++++++
 tb/tb_cv_key_matrix.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_key_matrix.sv
// Scan-code/joystick to 4x8 PIA key matrix: PS/2 set-2 decoder, joystick synchronizers
// and registered column readback. Optional joystick debounce via `CV_KEY_DEBOUNCE_EN.
module cv_key_matrix #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1024,
  parameter logic [15:0] PREFIX_TIMEOUT  = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic [6:0]  joy1,
  input  logic [6:0]  joy2,
  input  logic [7:0]  pa_in,
  output logic [7:0]  pb_out,
  output logic [31:0] key_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] kbd_q, kbd_d;
  logic [13:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [13:0] joy_eff;
  logic [7:0]  pb_q, pb_d;
  logic        key_we, key_set, key_ext;

  // One-hot matrix bit for a scan code; zero when the code is unmapped.
  function automatic logic [31:0] key_mask(input logic ext, input logic [7:0] code);
    logic [31:0] m;
    m = 32'd0;
    if (ext) begin
      case (code)
        8'h72:   m[1] = 1'b1;
        8'h74:   m[2] = 1'b1;
        8'h75:   m[3] = 1'b1;
        8'h6B:   m[5] = 1'b1;
        default: m = 32'd0;
      endcase
    end else begin
      case (code)
        8'h16: m[8]  = 1'b1;   8'h1E: m[9]  = 1'b1;
        8'h26: m[10] = 1'b1;   8'h25: m[11] = 1'b1;
        8'h2E: m[12] = 1'b1;   8'h36: m[13] = 1'b1;
        8'h3D: m[14] = 1'b1;   8'h3E: m[15] = 1'b1;
        8'h46: m[24] = 1'b1;   8'h45: m[25] = 1'b1;
        8'h15: m[26] = 1'b1;   8'h1D: m[27] = 1'b1;
        8'h24: m[28] = 1'b1;   8'h2D: m[29] = 1'b1;
        8'h2C: m[30] = 1'b1;   8'h35: m[31] = 1'b1;
        default: m = 32'd0;
      endcase
    end
    return m;
  endfunction

  function automatic logic [7:0] joy_row(input logic [6:0] j);
    return {j[5], 1'b0, j[1], 1'b0, j[3], j[0], j[2], 1'b0};
  endfunction

  function automatic logic [7:0] pad_row(input logic [6:0] j);
    return {j[4], j[6], 3'b000, j[6], 2'b00};
  endfunction

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Decoder next state, including the stale-prefix timeout.
  always_comb begin
    state_d = state_q;
    if (kbd_valid) begin
      case (state_q)
        ST_IDLE:    state_d = (kbd_data == 8'hF0) ? ST_BRK :
                              (kbd_data == 8'hE0) ? ST_EXT : ST_IDLE;
        ST_EXT:     state_d = (kbd_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == PREFIX_TIMEOUT - 16'd1)) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Decoder outputs: which matrix write, if any, this byte performs.
  always_comb begin
    key_we  = 1'b0;
    key_set = 1'b0;
    key_ext = 1'b0;
    if (kbd_valid) begin
      case (state_q)
        ST_IDLE: begin
          key_we  = (kbd_data != 8'hF0) && (kbd_data != 8'hE0);
          key_set = 1'b1;
        end
        ST_EXT: begin
          key_we  = (kbd_data != 8'hF0);
          key_set = 1'b1;
          key_ext = 1'b1;
        end
        ST_BRK:     key_we = 1'b1;
        ST_EXT_BRK: begin
          key_we  = 1'b1;
          key_ext = 1'b1;
        end
        default: key_we = 1'b0;
      endcase
    end else begin
      key_we = 1'b0;
    end
  end

  // Matrix, timeout and synchronizer next values; timeout only runs while a prefix is pending.
  always_comb begin
    kbd_d = kbd_q;
    if (key_we) begin
      if (key_set) kbd_d = kbd_q | key_mask(key_ext, kbd_data);
      else         kbd_d = kbd_q & ~key_mask(key_ext, kbd_data);
    end else begin
      kbd_d = kbd_q;
    end
    if (kbd_valid || (state_q == ST_IDLE) || (tmo_q == PREFIX_TIMEOUT - 16'd1)) tmo_d = 16'd0;
    else                                                                         tmo_d = tmo_q + 16'd1;
    sync1_d = {joy2, joy1};
    sync2_d = sync1_q;
  end

  // Keyboard matrix, timeout counter and joystick synchronizers.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q   <= 32'd0;
      tmo_q   <= 16'd0;
      sync1_q <= 14'd0;
      sync2_q <= 14'd0;
    end else begin
      kbd_q   <= kbd_d;
      tmo_q   <= tmo_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef CV_KEY_DEBOUNCE_EN
  logic [15:0] deb_cnt_q [14];
  logic [15:0] deb_cnt_d [14];
  logic [13:0] deb_acc_q, deb_acc_d;

  // A bit is accepted once it has disagreed with the accepted value for DEBOUNCE_CYCLES samples.
  always_comb begin
    deb_acc_d = deb_acc_q;
    for (int i = 0; i < 14; i++) begin
      deb_cnt_d[i] = 16'd0;
      if (sync2_q[i] != deb_acc_q[i]) begin
        if (deb_cnt_q[i] >= DEBOUNCE_CYCLES - 16'd1) deb_acc_d[i] = sync2_q[i];
        else                                          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end else begin
        deb_cnt_d[i] = 16'd0;
      end
    end
  end

  // Debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_acc_q <= 14'd0;
      for (int i = 0; i < 14; i++) deb_cnt_q[i] <= 16'd0;
    end else begin
      deb_acc_q <= deb_acc_d;
      for (int i = 0; i < 14; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign joy_eff = deb_acc_q;
  logic unused_pa;
  assign unused_pa = ^pa_in[7:4];
`else
  assign joy_eff = sync2_q;
  logic unused_cfg;
  assign unused_cfg = ^{pa_in[7:4], DEBOUNCE_CYCLES};
`endif

  assign key_state = kbd_q | {pad_row(joy_eff[13:7]), joy_row(joy_eff[13:7]),
                              pad_row(joy_eff[6:0]),  joy_row(joy_eff[6:0])};

  // Column readback: wired-AND of every selected row's active-low columns.
  always_comb begin
    pb_d = 8'hFF;
    for (int r = 0; r < 4; r++) begin
      if (!pa_in[r]) pb_d = pb_d & ~key_state[8*r +: 8];
      else           pb_d = pb_d;
    end
  end

  // Registered port B.
  always_ff @(posedge clk) begin
    if (reset) pb_q <= 8'hFF;
    else       pb_q <= pb_d;
  end

  assign pb_out = pb_q;

endmodule

// File: tb/tb_cv_key_matrix.sv
// Bench for cv_key_matrix: scan-code/joystick behavioural model checked every cycle,
// plus hand-computed literal checks. Honours `CV_KEY_DEBOUNCE_EN like the design.
module tb_cv_key_matrix;
  localparam int TMO = 50000;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic [6:0]  joy1, joy2;
  logic [7:0]  pa_in;
  logic [7:0]  pb_out;
  logic [31:0] key_state;

  int n_tests = 0;
  int n_fail  = 0;

  cv_key_matrix #(.DEBOUNCE_CYCLES(16'd4), .PREFIX_TIMEOUT(16'd50000)) dut (
    .clk(clk), .reset(reset), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .joy1(joy1), .joy2(joy2), .pa_in(pa_in), .pb_out(pb_out), .key_state(key_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  row1_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
  logic [7:0]  row3_codes [8] = '{8'h46, 8'h45, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
  logic [31:0] m_kb;          // keys held via the keyboard
  bit          m_ext, m_brk;  // prefixes seen but not yet consumed
  int          m_idle;
  logic [13:0] m_hist [2];    // joystick samples, [1] is the synchronized value
  logic [13:0] m_acc;
  int          m_run [14];
  logic [31:0] m_key;
  logic [7:0]  m_pb;
  bit          chk_en = 1'b0;

  function automatic int code_bit(input bit ext, input logic [7:0] c);
    if (ext) begin
      if (c == 8'h72) return 1;
      if (c == 8'h74) return 2;
      if (c == 8'h75) return 3;
      if (c == 8'h6B) return 5;
      return -1;
    end
    for (int i = 0; i < 8; i++) begin
      if (row1_codes[i] == c) return 8 + i;
      if (row3_codes[i] == c) return 24 + i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] joy_terms(input logic [6:0] a, input logic [6:0] b);
    logic [31:0] k;
    k = 32'd0;
    for (int p = 0; p < 2; p++) begin
      logic [6:0] j;
      j = (p == 0) ? a : b;
      k[16*p + 7]  = j[5];
      k[16*p + 5]  = j[1];
      k[16*p + 3]  = j[3];
      k[16*p + 2]  = j[0];
      k[16*p + 1]  = j[2];
      k[16*p + 15] = j[4];
      k[16*p + 14] = j[6];
      k[16*p + 10] = j[6];
    end
    return k;
  endfunction

  function automatic logic [7:0] pb_of(input logic [7:0] pa, input logic [31:0] k);
    logic [7:0] r;
    r = 8'hFF;
    for (int row = 0; row < 4; row++)
      if (pa[row] == 1'b0)
        for (int c = 0; c < 8; c++)
          if (k[8*row + c]) r[c] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [13:0] eff;
    int b;
    if (reset) begin
      m_kb = 32'd0; m_ext = 1'b0; m_brk = 1'b0; m_idle = 0;
      m_hist[0] = 14'd0; m_hist[1] = 14'd0; m_acc = 14'd0;
      for (int i = 0; i < 14; i++) m_run[i] = 0;
      m_key = 32'd0; m_pb = 8'hFF; chk_en = 1'b1;
    end else begin
      m_pb = pb_of(pa_in, m_key);
      if (kbd_valid) begin
        m_idle = 0;
        if (m_brk) begin
          b = code_bit(m_ext, kbd_data);
          if (b >= 0) m_kb[b] = 1'b0;
          m_ext = 1'b0; m_brk = 1'b0;
        end else if (m_ext) begin
          if (kbd_data == 8'hF0) m_brk = 1'b1;
          else begin
            b = code_bit(1'b1, kbd_data);
            if (b >= 0) m_kb[b] = 1'b1;
            m_ext = 1'b0;
          end
        end else if (kbd_data == 8'hF0) m_brk = 1'b1;
        else if (kbd_data == 8'hE0) m_ext = 1'b1;
        else begin
          b = code_bit(1'b0, kbd_data);
          if (b >= 0) m_kb[b] = 1'b1;
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_ext = 1'b0; m_brk = 1'b0; m_idle = 0;
        end
      end
      // accepted value follows a run of DEB disagreeing synchronized samples
      for (int i = 0; i < 14; i++) begin
        if (m_hist[1][i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_acc[i] = m_hist[1][i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = {joy2, joy1};
`ifdef CV_KEY_DEBOUNCE_EN
      eff = m_acc;
`else
      eff = m_hist[1];
`endif
      m_key = m_kb | joy_terms(eff[6:0], eff[13:7]);
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (key_state !== m_key) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL model_key_state t=%0t: got %h expected %h", $time, key_state, m_key);
      end
      n_tests++;
      if (pb_out !== m_pb) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL model_pb_out t=%0t: got %h expected %h", $time, pb_out, m_pb);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    kbd_data = b; kbd_valid = 1'b1;
    @(posedge clk); #2;
    kbd_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; kbd_data = 8'h00; kbd_valid = 1'b0;
    joy1 = 7'd0; joy2 = 7'd0; pa_in = 8'hFF;
    repeat (3) @(posedge clk); #2;
    reset = 1'b0;
    settle();
    check("reset_pb", {24'd0, pb_out}, 32'h0000_00FF);
    check("reset_keys", key_state, 32'd0);

    send(8'h1E); pa_in = 8'hFD; settle();
    check("make_1E_pb", {24'd0, pb_out}, 32'h0000_00FD);
    send(8'h1E); settle();
    check("make_1E_again", key_state, 32'h0000_0200);
    send(8'hF0); send(8'h1E); settle();
    check("break_1E_pb", {24'd0, pb_out}, 32'h0000_00FF);
    send(8'hF0); send(8'h1E); settle();
    check("break_1E_again", key_state, 32'd0);

    send(8'hE0); send(8'h75); pa_in = 8'hFE; settle();
    check("ext_75_pb", {24'd0, pb_out}, 32'h0000_00F7);
    send(8'h75); send(8'hE0); send(8'h16); settle();   // unmapped plain 75 and extended 16
    check("unmapped_codes", key_state, 32'h0000_0008);
    send(8'hE0); send(8'hF0); send(8'h75); settle();
    check("ext_break_pb", {24'd0, pb_out}, 32'h0000_00FF);

    joy2 = 7'h10; pa_in = 8'hF7; settle();
    check("joy2_fire1_pb", {24'd0, pb_out}, 32'h0000_007F);
    send(8'h16); pa_in = 8'hF5; settle();
    check("two_rows_pb", {24'd0, pb_out}, 32'h0000_007E);
    pa_in = 8'hF0; settle();
    send(8'hF0); send(8'h16); joy2 = 7'd0; settle();

    foreach (row3_codes[i]) send(row3_codes[i]);
    pa_in = 8'hF7; settle();
    check("row3_all", key_state, 32'hFF00_0000);
    check("row3_all_pb", {24'd0, pb_out}, 32'h0000_0000);
    foreach (row3_codes[i]) begin send(8'hF0); send(row3_codes[i]); end
    settle();
    check("row3_none", key_state, 32'd0);

    joy1 = 7'h7F; joy2 = 7'h2A; pa_in = 8'hFE; settle();
    pa_in = 8'hFD; settle();
    pa_in = 8'hFA; settle();
    check("joy_rows02_pb", {24'd0, pb_out}, 32'h0000_0051);
    joy1 = 7'd0; joy2 = 7'd0; pa_in = 8'hFF; settle();

    send(8'hE0);
    @(posedge clk); #2; reset = 1'b1;
    repeat (2) @(posedge clk); #2; reset = 1'b0;
    send(8'h75); settle();
    check("reset_drops_prefix", key_state, 32'd0);

    send(8'hE0);
    repeat (TMO) @(posedge clk);
    #2;
    send(8'h75); settle();
    check("prefix_timeout", key_state, 32'd0);

`ifdef CV_KEY_DEBOUNCE_EN
    joy1 = 7'h01; repeat (3) @(posedge clk); #2; joy1 = 7'd0;
    settle();
    check("debounce_short_pulse", {31'd0, key_state[2]}, 32'd0);
    joy1 = 7'h01; repeat (6) @(posedge clk); #2; joy1 = 7'd0;
    repeat (2) @(posedge clk); @(negedge clk); #1;
    check("debounce_long_hold", {31'd0, key_state[2]}, 32'd1);
`else
    joy1 = 7'h01; repeat (2) @(posedge clk); @(negedge clk); #1;
    check("sync_latency", {31'd0, key_state[2]}, 32'd1);
    @(posedge clk); #2; joy1 = 7'd0;
    settle();
    check("sync_release", {31'd0, key_state[2]}, 32'd0);
`endif
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
